// File: rtl/bmp_image_write_if.sv
// bmp_image_write_if: BMP byte stream with valid/ready handshake.
// The block drives bytes as master; the downstream sink is the slave.
interface bmp_image_write_if;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eof;

    modport master (
        output out_byte,
        output out_valid,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_byte,
        input  out_valid,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/bmp_image_write.sv
// bmp_image_write: captures an addressed RGB frame into a frame buffer and
// replays it as a complete 24-bit BMP byte stream (header + bottom-up rows).
module bmp_image_write #(
    parameter int MAX_WIDTH  = 1080,
    parameter int MAX_HEIGHT = 1080
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       in_width,
    input  logic [31:0]       in_height,
    input  logic              pix_valid,
    input  logic [10:0]       pix_row,
    input  logic [10:0]       pix_col,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              pix_last,
    bmp_image_write_if.master ob,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = MAX_WIDTH * MAX_HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] HDR_BYTES = 32'd54;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HEADER,
        PIXELS,
        DONE
    } state_t;

    state_t      state_q;
    logic [10:0] w_q;
    logic [10:0] h_q;
    logic [31:0] cnt_q;
    logic [10:0] ecol_q;
    logic [1:0]  comp_q;
    logic [1:0]  padc_q;
    logic [10:0] frow_q;
    logic [10:0] fcol_q;
    logic [15:0] hold_q;
    logic [23:0] rd_q;
    logic [7:0]  byte_q;
    logic        valid_q;
    logic        sof_q;
    logic        eof_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [23:0] fb [DEPTH];

    logic          is_idle;
    logic          idle_ok;
    logic          cap_ok;
    logic          in_rng;
    logic          wr_en;
    logic [10:0]   cap_w;
    logic [10:0]   cap_h;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;

    assign is_idle = (state_q == IDLE);
    assign idle_ok = (in_width != 32'd0) && (in_height != 32'd0)
                  && (in_width <= 32'(MAX_WIDTH))
                  && (in_height <= 32'(MAX_HEIGHT));
    assign cap_w  = is_idle ? in_width[10:0] : w_q;
    assign cap_h  = is_idle ? in_height[10:0] : h_q;
    assign cap_ok = (is_idle && idle_ok) || (state_q == CAPTURE);
    assign in_rng = (pix_row < cap_h) && (pix_col < cap_w);
    assign wr_en  = pix_valid && cap_ok && in_rng;
    assign wa     = AW'(pix_row) * AW'(cap_w) + AW'(pix_col);
    assign ra     = AW'(frow_q) * AW'(w_q) + AW'(fcol_q);

    // Read port runs every cycle on the fetch pointer, one pixel ahead of emission.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fb[wa] <= {pix_r, pix_g, pix_b};
        end
        rd_q <= fb[ra];
    end

    logic [12:0] w3;
    logic [12:0] stride;
    logic [1:0]  pad;
    logic [31:0] isize;
    logic [31:0] fsize;

    assign w3     = {2'b00, w_q} + {1'b0, w_q, 1'b0};
    assign pad    = 2'd0 - w3[1:0];
    assign stride = w3 + {11'd0, pad};
    assign isize  = {19'd0, stride} * {21'd0, h_q};
    assign fsize  = isize + HDR_BYTES;

    logic [5:0]  hsel;
    logic [31:0] hfld;
    logic [7:0]  hbyte;

    // Header is a run of little-endian words starting at byte 2; bytes 0..1 wrap to word 15.
    always_comb begin
        hsel = cnt_q[5:0] - 6'd2;
        hfld = 32'd0;
        case (hsel[5:2])
            4'd0:    hfld = fsize;
            4'd2:    hfld = 32'd54;
            4'd3:    hfld = 32'd40;
            4'd4:    hfld = {21'd0, w_q};
            4'd5:    hfld = {21'd0, h_q};
            4'd6:    hfld = {16'd24, 16'd1};
            4'd8:    hfld = isize;
            4'd9:    hfld = 32'd2835;
            4'd10:   hfld = 32'd2835;
            4'd15:   hfld = 32'h4D42_0000;
            default: hfld = 32'd0;
        endcase
        hbyte = hfld[{hsel[1:0], 3'b000} +: 8];
    end

    logic       in_hdr;
    logic       xfer;
    logic       eof_d;
    logic [7:0] byte_d;
    logic [10:0] wm1;

    assign in_hdr = (cnt_q < HDR_BYTES);
    assign xfer   = valid_q && ob.out_ready;
    assign eof_d  = (cnt_q == fsize - 32'd1);
    assign wm1    = w_q - 11'd1;

    always_comb begin
        byte_d = 8'h00;
        if (in_hdr) begin
            byte_d = hbyte;
        end else begin
            unique case (1'b1)
                (comp_q == 2'd0): byte_d = rd_q[23:16];
                (comp_q == 2'd1): byte_d = hold_q[15:8];
                (comp_q == 2'd2): byte_d = hold_q[7:0];
                (comp_q == 2'd3): byte_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            w_q     <= 11'd0;
            h_q     <= 11'd0;
            cnt_q   <= 32'd0;
            ecol_q  <= 11'd0;
            comp_q  <= 2'd0;
            padc_q  <= 2'd0;
            frow_q  <= 11'd0;
            fcol_q  <= 11'd0;
            hold_q  <= 16'd0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, CAPTURE: begin
                    if (pix_valid) begin
                        if (!cap_ok || !in_rng) begin
                            err_q <= 1'b1;
                        end
                        if (cap_ok) begin
                            if (is_idle) begin
                                w_q     <= cap_w;
                                h_q     <= cap_h;
                                busy_q  <= 1'b1;
                                state_q <= CAPTURE;
                            end
                            if (pix_last) begin
                                state_q <= HEADER;
                                byte_q  <= 8'h42;
                                valid_q <= 1'b1;
                                sof_q   <= 1'b1;
                                eof_q   <= 1'b0;
                                cnt_q   <= 32'd1;
                                frow_q  <= cap_h - 11'd1;
                                fcol_q  <= 11'd0;
                                ecol_q  <= 11'd0;
                                comp_q  <= 2'd0;
                                padc_q  <= 2'd0;
                            end
                        end
                    end
                end
                HEADER, PIXELS: begin
                    if (pix_valid) begin
                        err_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (eof_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            eof_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            byte_q <= byte_d;
                            sof_q  <= 1'b0;
                            eof_q  <= eof_d;
                            cnt_q  <= cnt_q + 32'd1;
                            if (!in_hdr) begin
                                state_q <= PIXELS;
                                unique case (1'b1)
                                    (comp_q == 2'd0): begin
                                        hold_q <= rd_q[15:0];
                                        comp_q <= 2'd1;
                                        if (fcol_q == wm1) begin
                                            fcol_q <= 11'd0;
                                            if (frow_q != 11'd0) begin
                                                frow_q <= frow_q - 11'd1;
                                            end
                                        end else begin
                                            fcol_q <= fcol_q + 11'd1;
                                        end
                                    end
                                    (comp_q == 2'd1): comp_q <= 2'd2;
                                    (comp_q == 2'd2): begin
                                        padc_q <= 2'd0;
                                        if (ecol_q == wm1) begin
                                            ecol_q <= 11'd0;
                                            comp_q <= (pad == 2'd0) ? 2'd0 : 2'd3;
                                        end else begin
                                            ecol_q <= ecol_q + 11'd1;
                                            comp_q <= 2'd0;
                                        end
                                    end
                                    (comp_q == 2'd3): begin
                                        if (padc_q == pad - 2'd1) begin
                                            comp_q <= 2'd0;
                                        end else begin
                                            padc_q <= padc_q + 2'd1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end
                DONE: begin
                    if (pix_valid) begin
                        err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ob.out_byte  = byte_q;
    assign ob.out_valid = valid_q;
    assign ob.out_sof   = sof_q;
    assign ob.out_eof   = eof_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_bmp_image_write.sv
// tb_bmp_image_write: directed + randomized frames checked against a
// byte-level BMP file model built from W, H and the pixel image.
`timescale 1ns/1ps
module tb_bmp_image_write;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] in_width;
    logic [31:0] in_height;
    logic        pix_valid;
    logic [10:0] pix_row;
    logic [10:0] pix_col;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_last;
    logic        busy;
    logic        done;
    logic        err;

    bmp_image_write_if bif();

    bmp_image_write dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_width  (in_width),
        .in_height (in_height),
        .pix_valid (pix_valid),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_last  (pix_last),
        .ob        (bif),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [23:0] img [16][16];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  ref_q[$];
    int n_sof, n_eof, n_done, stall_bad, done_bad;
    bit eof_seen;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void put_le(input int unsigned v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endfunction

    // Expected BMP file: header fields, then image rows bottom-up with padding.
    function automatic void model(input int w, input int h);
        int pad, stride, isize;
        pad    = (4 - (3 * w) % 4) % 4;
        stride = 3 * w + pad;
        isize  = stride * h;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        put_le(54 + isize, 4); put_le(0, 4); put_le(54, 4); put_le(40, 4);
        put_le(w, 4); put_le(h, 4); put_le(1, 2); put_le(24, 2);
        put_le(0, 4); put_le(isize, 4); put_le(2835, 4); put_le(2835, 4);
        put_le(0, 4); put_le(0, 4);
        for (int k = 0; k < h; k++) begin
            for (int c = 0; c < w; c++) begin
                exp_q.push_back(img[h - 1 - k][c][23:16]);
                exp_q.push_back(img[h - 1 - k][c][15:8]);
                exp_q.push_back(img[h - 1 - k][c][7:0]);
            end
            for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
        end
    endfunction

    task automatic drive(input int w, input int h, input bit shuffle, input bit bad);
        int rs[$];
        int cs[$];
        logic [23:0] ds[$];
        int j, t;
        logic [23:0] td;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                rs.push_back(r); cs.push_back(c); ds.push_back(img[r][c]);
            end
        if (shuffle) begin
            for (int i = rs.size() - 1; i > 0; i--) begin
                j = int'($urandom_range(i));
                t = rs[i]; rs[i] = rs[j]; rs[j] = t;
                t = cs[i]; cs[i] = cs[j]; cs[j] = t;
                td = ds[i]; ds[i] = ds[j]; ds[j] = td;
            end
            for (int i = 0; i < 3; i++) begin
                rs.push_front(int'($urandom_range(h - 1)));
                cs.push_front(int'($urandom_range(w - 1)));
                ds.push_front(24'($urandom));
            end
        end
        if (bad) begin
            rs.insert(rs.size() - 1, h);
            cs.insert(cs.size() - 1, 0);
            ds.insert(ds.size() - 1, 24'hBADBAD);
        end
        for (int i = 0; i < rs.size(); i++) begin
            @(negedge CLK);
            pix_valid = 1'b1;
            pix_row   = 11'(rs[i]);
            pix_col   = 11'(cs[i]);
            {pix_r, pix_g, pix_b} = ds[i];
            pix_last  = (i == rs.size() - 1);
        end
        @(negedge CLK);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic start_check(input string tag);
        check({tag, "_start_valid"}, bif.out_valid, 1);
        check({tag, "_start_byte"}, bif.out_byte, 8'h42);
        check({tag, "_start_sof"}, bif.out_sof, 1);
        check({tag, "_start_busy"}, busy, 1);
    endtask

    task automatic collect(input int pct, input bit inj, input int abort_at);
        bit rdy, pv, wait_done;
        logic [7:0] pb;
        logic ps, pe;
        int after;
        got_q.delete();
        n_sof = 0; n_eof = 0; n_done = 0; stall_bad = 0; done_bad = 0;
        eof_seen = 0; after = 0; pv = 0; wait_done = 0; pb = 0; ps = 0; pe = 0;
        for (int cyc = 0; cyc < 5000 && after < 4; cyc++) begin
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                #2 RESET = 1'b0;
                #1;
                check("abort_valid", bif.out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_err", err, 0);
                pix_valid = 1'b0;
                bif.out_ready = 1'b0;
                return;
            end
            rdy = ($urandom_range(99) < pct);
            bif.out_ready = rdy;
            if (inj && got_q.size() >= 3 && got_q.size() < 6) begin
                pix_valid = 1'b1;
                pix_row = 11'($urandom_range(1));
                pix_col = 11'($urandom_range(1));
                {pix_r, pix_g, pix_b} = 24'($urandom);
            end else begin
                pix_valid = 1'b0;
            end
            if (wait_done) begin
                if (!done || busy) done_bad++;
                wait_done = 0;
            end
            if (done) n_done++;
            if (pv && (bif.out_byte !== pb || bif.out_sof !== ps || bif.out_eof !== pe))
                stall_bad++;
            if (!eof_seen && !bif.out_valid) stall_bad++;
            pv = bif.out_valid && !rdy;
            pb = bif.out_byte; ps = bif.out_sof; pe = bif.out_eof;
            if (bif.out_valid && rdy) begin
                got_q.push_back(bif.out_byte);
                n_sof += int'(bif.out_sof);
                n_eof += int'(bif.out_eof);
                if (bif.out_eof) begin
                    eof_seen = 1;
                    wait_done = 1;
                end
            end
            if (eof_seen) after++;
            @(negedge CLK);
        end
        pix_valid = 1'b0;
        bif.out_ready = 1'b0;
        check("eof_reached", eof_seen, 1);
    endtask

    task automatic compare(input string tag);
        int bad;
        bad = 0;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_bytes"}, bad, 0);
        check({tag, "_sof"}, n_sof, 1);
        check({tag, "_eof"}, n_eof, 1);
        check({tag, "_done"}, n_done, 1);
        check({tag, "_done_cycle"}, done_bad, 0);
        check({tag, "_stall"}, stall_bad, 0);
    endtask

    task automatic set_2x2();
        img[0][0] = 24'h0A141E; img[0][1] = 24'h28323C;
        img[1][0] = 24'h010203; img[1][1] = 24'h040506;
        in_width = 32'd2; in_height = 32'd2;
    endtask

    task automatic idle_probe(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (bif.out_valid || busy) bad++;
            @(negedge CLK);
        end
        check({tag, "_quiet"}, bad, 0);
        check({tag, "_err"}, err, 1);
    endtask

    logic [7:0] dlit [16];
    int bad2;

    initial begin
        dlit = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00,
                 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h00, 8'h00};
        RESET = 1'b0;
        in_width = 0; in_height = 0;
        pix_valid = 0; pix_row = 0; pix_col = 0;
        pix_r = 0; pix_g = 0; pix_b = 0; pix_last = 0;
        bif.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_valid", bif.out_valid, 0);
        check("rst_byte", bif.out_byte, 0);
        check("rst_sof", bif.out_sof, 0);
        check("rst_eof", bif.out_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // 2x2 frame, sink always ready
        set_2x2();
        drive(2, 2, 0, 0);
        start_check("f2x2");
        collect(100, 0, -1);
        model(2, 2);
        compare("f2x2");
        if (got_q.size() == 70) begin
            check("f2x2_fsize", {got_q[5], got_q[4], got_q[3], got_q[2]}, 32'h46);
            check("f2x2_isize", {got_q[37], got_q[36], got_q[35], got_q[34]}, 32'h10);
            bad2 = 0;
            for (int i = 0; i < 16; i++) if (got_q[54 + i] !== dlit[i]) bad2++;
            check("f2x2_data", bad2, 0);
        end
        check("f2x2_err", err, 0);
        ref_q = got_q;

        // 3x1 with three pad bytes, then 4x1 with none
        for (int c = 0; c < 4; c++) img[0][c] = 24'($urandom);
        in_width = 3; in_height = 1;
        drive(3, 1, 0, 0);
        start_check("f3x1");
        collect(100, 0, -1);
        model(3, 1);
        compare("f3x1");
        if (got_q.size() == 66)
            check("f3x1_pad", {got_q[63], got_q[64], got_q[65]}, 0);
        in_width = 4; in_height = 1;
        drive(4, 1, 1, 0);
        collect(100, 0, -1);
        model(4, 1);
        compare("f4x1");

        // 2x2 under random backpressure
        set_2x2();
        drive(2, 2, 0, 0);
        collect(50, 0, -1);
        model(2, 2);
        compare("f2x2_bp");
        bad2 = (got_q.size() == ref_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) bad2++;
        check("f2x2_bp_same", bad2, 0);

        // random sizes, shuffled order with overwritten decoys
        for (int t = 0; t < 4; t++) begin
            int w, h;
            w = int'($urandom_range(1, 9));
            h = int'($urandom_range(1, 6));
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) img[r][c] = 24'($urandom);
            in_width = w; in_height = h;
            drive(w, h, 1, 0);
            start_check("frand");
            collect(70, 0, -1);
            model(w, h);
            compare("frand");
        end
        check("frand_err", err, 0);

        // reset while emitting byte 30, then a fresh frame
        set_2x2();
        drive(2, 2, 0, 0);
        collect(100, 0, 30);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        drive(2, 2, 0, 0);
        start_check("fresh");
        collect(100, 0, -1);
        model(2, 2);
        compare("fresh");
        check("fresh_err", err, 0);

        // pixels pulsed during HEADER are ignored but flagged
        drive(2, 2, 0, 0);
        collect(100, 1, -1);
        model(2, 2);
        compare("hdr_inj");
        check("hdr_inj_err", err, 1);

        // out-of-range row is dropped, stream unchanged
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        check("rst2_err", err, 0);
        set_2x2();
        drive(2, 2, 0, 1);
        collect(100, 0, -1);
        model(2, 2);
        compare("badrow");
        check("badrow_err", err, 1);

        // zero width: nothing captured or emitted
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        in_width = 0; in_height = 2;
        drive(2, 2, 0, 0);
        idle_probe("w0");

        // width beyond the maximum
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        in_width = 1081; in_height = 2;
        drive(2, 2, 0, 0);
        idle_probe("wmax");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bmp_image_write.md
# bmp_image_write

Image sink at the output end of the processing pipeline. Consumes the addressed RGB pixel stream from the image read/process stage (row, column, R/G/B, width/height, done flag) into an internal frame buffer. Once the frame is complete, serializes it as a complete 24-bit BMP byte stream: 54-byte header, then bottom-up rows padded to 4 bytes, on a valid/ready byte interface. The output feeds the hex-dump/file-write bench and any downstream byte sink.

## Interface
- MAX_WIDTH, 1080, largest accepted image width in pixels
- MAX_HEIGHT, 1080, largest accepted image height in pixels

Ports (reset RESET, asynchronous, active-low; clock CLK):
- CLK  in  1  clock
- RESET  in  1  asynchronous active-low reset
- in_width  in  32  image width for the incoming frame
- in_height  in  32  image height for the incoming frame
- pix_valid  in  1  pixel present this cycle
- pix_row  in  11  pixel row, 0 = top
- pix_col  in  11  pixel column, 0 = left
- pix_r, pix_g, pix_b  in  8 each  pixel components
- pix_last  in  1  final pixel of frame; qualified by pix_valid
- out_byte  out  8  BMP byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts byte
- out_sof  out  1  high with header byte 0
- out_eof  out  1  high with the last file byte
- busy  out  1  frame capture or emission in progress
- done  out  1  one-cycle pulse after the last byte transfers
- err  out  1  sticky error flag; cleared only by reset

## Operation
- States: IDLE, CAPTURE, HEADER, PIXELS, DONE.
- IDLE, on the first pix_valid:
  - in_width and in_height are latched as W and H.
  - If W==0, H==0, W>MAX_WIDTH or H>MAX_HEIGHT: set err, drop the pixel, stay in IDLE.
  - Otherwise store the pixel and go to CAPTURE, or go directly to HEADER if pix_last is also set.
- CAPTURE:
  - Each pix_valid writes fb[pix_row*W+pix_col] = {R,G,B}.
  - Pixels with pix_row>=H or pix_col>=W are dropped and set err.
  - Duplicate addresses overwrite; the last write wins.
  - Unwritten locations emit whatever the buffer holds (undefined).
  - pix_valid&&pix_last performs the write, then moves to HEADER.
- Derived values:
  - pad = (4 − (3W mod 4)) mod 4
  - stride = 3W + pad
  - isize = stride·H
  - fsize = 54 + isize
- HEADER emits 54 bytes, all multi-byte fields little-endian:
  - 0x42, 0x4D
  - fsize (4 bytes)
  - 0 (4 bytes)
  - 54 (4 bytes)
  - 40 (4 bytes)
  - W (4 bytes)
  - H (4 bytes)
  - 1 (2 bytes)
  - 24 (2 bytes)
  - 0 (4 bytes)
  - isize (4 bytes)
  - 2835 (4 bytes)
  - 2835 (4 bytes)
  - 0 (8 bytes)
- PIXELS:
  - File row k = 0..H−1 carries image row H−1−k.
  - Each pixel is emitted as bytes R, G, B, columns in order 0..W−1 (team hex-image convention).
  - Each row is followed by pad bytes of 0x00.
- The last file byte carries out_eof. After it transfers, go to DONE: done=1 for one cycle, then IDLE.
- pix_valid outside IDLE/CAPTURE is ignored and sets err.
- Counters:
  - 32-bit byte counter; row/column counters 11 bits.
  - Address arithmetic wide enough for MAX_WIDTH·MAX_HEIGHT−1 (21 bits at the defaults).

## Timing
- Reset values:
  - out_valid, out_sof, out_eof, busy, done, err = 0
  - out_byte = 0x00
  - state = IDLE
  - All counters = 0
- Reset mid-operation abandons the frame; out_valid drops asynchronously. Frame buffer contents are not cleared.
- Capture: 1 pixel/cycle, no backpressure on the pixel side.
- busy:
  - Goes high the cycle after the first accepted pixel.
  - Goes low in the DONE cycle.
- Emission start: the cycle after the pix_last transfer, the block is in HEADER with out_valid=1, out_byte=0x42 and out_sof=1.
- Handshake:
  - A byte transfers on out_valid&&out_ready.
  - While out_valid&&!out_ready, out_byte, out_sof and out_eof hold stable.
  - out_valid never drops before eof has transferred.
- Throughput: with out_ready held high, exactly fsize consecutive transfer cycles and no bubbles, including the HEADER→PIXELS, row-boundary and pad transitions. The frame-buffer read latency (1 cycle, synchronous) is hidden by prefetch.
- done is asserted the cycle after the eof transfer.

## Test plan
- 2×2 frame (top row (10,20,30),(40,50,60); bottom row (1,2,3),(4,5,6)), out_ready=1 → 70 bytes.
  - Header bytes 2..5 = 46 00 00 00; bytes 34..37 = 10 00 00 00.
  - Data = 01 02 03 04 05 06 00 00 0A 14 1E 28 32 3C 00 00.
  - done pulses once.
- 3×1 frame → pad=3, fsize=66; bytes 54..65 = 9 pixel bytes then 00 00 00. 4×1 frame → pad=0, fsize=66.
- 2×2 frame with out_ready toggled by a random 50% pattern → byte sequence identical to the first scenario; out_byte stable during stalls; one out_sof and one out_eof.
- Pixel at row=2 on a 2×2 frame → dropped, err=1, remaining output unchanged. Frame with in_width=0 → err=1, no output, busy stays 0.
- RESET low while emitting byte 30 → out_valid=0 immediately, state IDLE, err=0. A following fresh 2×2 frame produces the correct 70 bytes.
- pix_valid pulses during HEADER → ignored, err=1, emitted stream unchanged.
